// File: rtl/irq_pkg.sv
// Register map shared by the interrupt controller and its bus decode.
package irq_pkg;

    localparam int unsigned IRQ_ADDR_W = 2;

    typedef enum logic [IRQ_ADDR_W-1:0] {
        IRQ_PEND = 2'd0,
        IRQ_EN   = 2'd1,
        IRQ_EDGE = 2'd2,
        IRQ_CTRL = 2'd3
    } irq_reg_e;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Priority encoder: returns the 1-based index of the highest set request, 0 if none.
module prio_enc #(
    parameter int unsigned VBITS = 4,
    parameter int unsigned NREQ  = (1 << VBITS) - 1
) (
    input  logic [NREQ-1:0]  req,
    output logic [VBITS-1:0] vec
);

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        vec = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                vec = VBITS'(i + 1);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: edge/level capture, masking, vector select, iack retire.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned     WIDTH    = 18,
    parameter int unsigned     NSRC     = 15,
    parameter int unsigned     VBITS    = 4,
    parameter logic [NSRC-1:0] EN_RST   = '1,
    parameter logic [NSRC-1:0] EDGE_RST = '1
) (
    input  logic                  clk,
    input  logic                  p_reset_n,
    input  logic                  io_rd,
    input  logic                  io_wr,
    input  logic [IRQ_ADDR_W-1:0] io_addr,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      io_dout,
    input  logic [NSRC-1:0]       src,
    output logic                  irq,
    output logic [VBITS-1:0]      ivec,
    input  logic                  iack
);

    logic [NSRC-1:0]  pending;
    logic [NSRC-1:0]  src_d;
    logic [NSRC-1:0]  enable;
    logic [NSRC-1:0]  edge_mode;
    logic             gie;

    logic             wr_pend;
    logic             wr_en;
    logic             wr_edge;
    logic             wr_ctrl;
    logic             holdoff;
    logic [NSRC-1:0]  ack_mask;
    logic [NSRC-1:0]  set_mask;
    logic [NSRC-1:0]  clr_mask;
    logic [NSRC-1:0]  pending_nxt;
    logic [NSRC-1:0]  req;
    logic [VBITS-1:0] winner;
    logic             irq_nxt;
    logic [WIDTH-1:0] rdata;

    // Only bits up to GIE carry meaning on writes.
    if (WIDTH > NSRC + 1) begin : g_unused_din
        logic unused_din;
        assign unused_din = ^din[WIDTH-1:NSRC+1];
    end

    // Bus write decode, pending next-state and interrupt qualification.
    always_comb begin
        wr_pend  = io_wr && (io_addr == IRQ_PEND);
        wr_en    = io_wr && (io_addr == IRQ_EN);
        wr_edge  = io_wr && (io_addr == IRQ_EDGE);
        wr_ctrl  = io_wr && (io_addr == IRQ_CTRL);

        // A valid acknowledge masks irq for the cycle in which its pending bit retires.
        holdoff  = iack && irq && (ivec != '0);
        ack_mask = holdoff ? (NSRC'(1) << (ivec - VBITS'(1))) : '0;

        set_mask = (src & ~src_d) | (wr_ctrl ? din[NSRC-1:0] : '0);
        clr_mask = (wr_pend ? din[NSRC-1:0] : '0) | ack_mask;

        // Sets beat clears in edge mode; level-mode bits simply follow the source.
        pending_nxt = (edge_mode & (set_mask | (pending & ~clr_mask)))
                    | (~edge_mode & src);

        req     = pending & enable;
        irq_nxt = gie && (req != '0) && !holdoff;
    end

    prio_enc #(
        .VBITS (VBITS),
        .NREQ  (NSRC)
    ) u_prio_enc (
        .req (req),
        .vec (winner)
    );

    // Register readback, zero-extended and gated by the read strobe.
    always_comb begin
        rdata = '0;
        case (io_addr)
            IRQ_PEND: rdata = WIDTH'(pending);
            IRQ_EN:   rdata = WIDTH'(enable);
            IRQ_EDGE: rdata = WIDTH'(edge_mode);
            IRQ_CTRL: rdata = WIDTH'({gie, req});
            default:  rdata = '0;
        endcase
        io_dout = io_rd ? rdata : '0;
    end

    // Controller state and registered irq/ivec.
    always_ff @(posedge clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            pending   <= '0;
            src_d     <= '0;
            enable    <= EN_RST;
            edge_mode <= EDGE_RST;
            gie       <= 1'b1;
            irq       <= 1'b0;
            ivec      <= '0;
        end else begin
            pending <= pending_nxt;
            src_d   <= src;
            if (wr_en) begin
                enable <= din[NSRC-1:0];
            end
            if (wr_edge) begin
                edge_mode <= din[NSRC-1:0];
            end
            if (wr_ctrl) begin
                gie <= din[NSRC];
            end
            irq  <= irq_nxt;
            ivec <= irq_nxt ? winner : '0;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_irq_ctrl;

    localparam int WIDTH = 18;
    localparam int NSRC  = 15;
    localparam int VBITS = 4;

    logic             clk = 1'b0;
    logic             p_reset_n = 1'b0;
    logic             io_rd = 1'b0;
    logic             io_wr = 1'b0;
    logic [1:0]       io_addr = '0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] io_dout;
    logic [NSRC-1:0]  src = '0;
    logic             irq;
    logic [VBITS-1:0] ivec;
    logic             iack = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk       (clk),
        .p_reset_n (p_reset_n),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .din       (din),
        .io_dout   (io_dout),
        .src       (src),
        .irq       (irq),
        .ivec      (ivec),
        .iack      (iack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_pend [1:NSRC];
    bit m_en   [1:NSRC];
    bit m_edge [1:NSRC];
    bit m_srcd [1:NSRC];
    bit np     [1:NSRC];
    bit m_gie;
    bit m_irq;
    int m_ivec;
    bit ack_ok;
    int best;

    function automatic logic [WIDTH-1:0] m_read(input logic [1:0] a);
        int v;
        v = 0;
        for (int i = 1; i <= NSRC; i++) begin
            case (a)
                2'd0: if (m_pend[i]) v += (1 << (i - 1));
                2'd1: if (m_en[i]) v += (1 << (i - 1));
                2'd2: if (m_edge[i]) v += (1 << (i - 1));
                default: if (m_pend[i] && m_en[i]) v += (1 << (i - 1));
            endcase
        end
        if (a == 2'd3 && m_gie) v += (1 << NSRC);
        return WIDTH'(v);
    endfunction

    // Model advances on every clock from the same inputs the DUT sees, then compares.
    always @(posedge clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            for (int i = 1; i <= NSRC; i++) begin
                m_pend[i] = 0; m_srcd[i] = 0; m_en[i] = 1; m_edge[i] = 1;
            end
            m_gie = 1; m_irq = 0; m_ivec = 0;
        end else begin
            ack_ok = iack && m_irq && (m_ivec != 0);
            best = 0;
            for (int i = 1; i <= NSRC; i++) begin
                if (m_pend[i] && m_en[i]) best = i;
            end
            for (int i = 1; i <= NSRC; i++) begin
                if (!m_edge[i]) begin
                    np[i] = src[i-1];
                end else begin
                    np[i] = m_pend[i];
                    if (io_wr && io_addr == 2'd0 && din[i-1]) np[i] = 0;
                    if (ack_ok && m_ivec == i) np[i] = 0;
                    if (src[i-1] && !m_srcd[i]) np[i] = 1;
                    if (io_wr && io_addr == 2'd3 && din[i-1]) np[i] = 1;
                end
            end
            m_irq  = m_gie && (best != 0) && !ack_ok;
            m_ivec = m_irq ? best : 0;
            for (int i = 1; i <= NSRC; i++) begin
                m_pend[i] = np[i];
                m_srcd[i] = src[i-1];
                if (io_wr && io_addr == 2'd1) m_en[i] = din[i-1];
                if (io_wr && io_addr == 2'd2) m_edge[i] = din[i-1];
            end
            if (io_wr && io_addr == 2'd3) m_gie = din[NSRC];
            #1;
            check("mdl_irq", 32'(irq), 32'(m_irq));
            check("mdl_ivec", 32'(ivec), 32'(m_ivec));
            if (io_rd) check("mdl_rdata", 32'(io_dout), 32'(m_read(io_addr)));
        end
    end

    // ---------------- stimulus helpers (all start and end at a negedge) ----------------
    task automatic rd(input logic [1:0] a, input logic [WIDTH-1:0] e, input string n);
        io_rd = 1'b1; io_addr = a;
        #1;
        check(n, 32'(io_dout), 32'(e));
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
        io_wr = 1'b1; io_addr = a; din = d;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic pulse(input logic [NSRC-1:0] m);
        src = m;
        @(negedge clk);
        src = '0;
    endtask

    task automatic ack();
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
    endtask

    task automatic chk_out(input string n, input logic ei, input logic [VBITS-1:0] ev);
        check({n, "_irq"}, 32'(irq), 32'(ei));
        check({n, "_ivec"}, 32'(ivec), 32'(ev));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_out("rst", 1'b0, 4'd0);
        p_reset_n = 1'b1;
        @(negedge clk);

        // Reset register values
        rd(2'd0, 18'h00000, "rst_pend");
        rd(2'd1, 18'h07FFF, "rst_en");
        rd(2'd2, 18'h07FFF, "rst_edge");
        rd(2'd3, 18'h08000, "rst_ctrl");

        // Single edge: two-cycle latency, then retire
        pulse(15'h0004);
        chk_out("t2_lat1", 1'b0, 4'd0);
        @(negedge clk);
        chk_out("t2_lat2", 1'b1, 4'd3);
        ack();
        chk_out("t2_ack", 1'b0, 4'd0);
        rd(2'd0, 18'h0, "t2_pend");

        // Two sources: highest first, lower after one holdoff cycle
        pulse(15'h0011);
        chk_out("t3_lat1", 1'b0, 4'd0);
        @(negedge clk);
        chk_out("t3_v5", 1'b1, 4'd5);
        ack();
        chk_out("t3_hold", 1'b0, 4'd0);
        @(negedge clk);
        chk_out("t3_v1", 1'b1, 4'd1);
        ack();
        chk_out("t3_done0", 1'b0, 4'd0);
        repeat (2) begin
            @(negedge clk);
            chk_out("t3_done", 1'b0, 4'd0);
        end

        // Level mode on source 7
        wr(2'd2, 18'h07F7F);
        src = 15'h0080;
        repeat (2) @(negedge clk);
        chk_out("t4_lvl", 1'b1, 4'd8);
        ack();
        chk_out("t4_hold", 1'b0, 4'd0);
        @(negedge clk);
        chk_out("t4_again", 1'b1, 4'd8);
        src = '0;
        repeat (2) @(negedge clk);
        chk_out("t4_drop", 1'b0, 4'd0);
        wr(2'd2, 18'h07FFF);

        // New edge in the same cycle as its iack is kept
        pulse(15'h0002);
        @(negedge clk);
        chk_out("t5_v2", 1'b1, 4'd2);
        src = 15'h0002; iack = 1'b1;
        @(negedge clk);
        src = '0; iack = 1'b0;
        chk_out("t5_hold", 1'b0, 4'd0);
        rd(2'd0, 18'h00002, "t5_pend");
        chk_out("t5_again", 1'b1, 4'd2);
        ack();
        rd(2'd0, 18'h0, "t5_pend0");

        // Masked source keeps pending; re-enable; software set; GIE gating; W1C
        wr(2'd1, 18'h0);
        pulse(15'h0008);
        @(negedge clk);
        chk_out("t6_masked", 1'b0, 4'd0);
        rd(2'd0, 18'h00008, "t6_pend");
        wr(2'd1, 18'h07FFF);
        chk_out("t6_wen", 1'b0, 4'd0);
        @(negedge clk);
        chk_out("t6_v4", 1'b1, 4'd4);
        ack();
        wr(2'd3, 18'h08040);
        @(negedge clk);
        chk_out("t6_v7", 1'b1, 4'd7);
        wr(2'd3, 18'h00000);
        @(negedge clk);
        chk_out("t6_gie0", 1'b0, 4'd0);
        rd(2'd3, 18'h00040, "t6_ctrl");
        wr(2'd3, 18'h08000);
        @(negedge clk);
        chk_out("t6_gie1", 1'b1, 4'd7);
        ack();
        pulse(15'h0020);
        @(negedge clk);
        chk_out("w1c_v6", 1'b1, 4'd6);
        wr(2'd0, 18'h00020);
        @(negedge clk);
        chk_out("w1c_clr", 1'b0, 4'd0);
        rd(2'd0, 18'h0, "w1c_pend");

        // Reset while an interrupt is up
        pulse(15'h0200);
        @(negedge clk);
        chk_out("rstmid_pre", 1'b1, 4'd10);
        #2 p_reset_n = 1'b0;
        #1 chk_out("rstmid", 1'b0, 4'd0);
        @(negedge clk);
        p_reset_n = 1'b1;
        rd(2'd0, 18'h0, "rstmid_pend");
        rd(2'd1, 18'h07FFF, "rstmid_en");

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            src     = src ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
            iack    = ($urandom_range(0, 3) == 0);
            io_wr   = ($urandom_range(0, 15) == 0);
            io_rd   = 1'($urandom_range(0, 1));
            io_addr = 2'($urandom);
            din     = WIDTH'($urandom);
            @(negedge clk);
        end
        src = '0; iack = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
